lc3b_writeback_buffer: RTL

LC3B_WRITEBACK_BUFFER -- requirements
Module: lc3b_writeback_buffer

---
 rtl/lc3b_types.sv | 11 +
 rtl/lc3b_writeback_buffer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: line-address typedef and the write-back drain states.
package lc3b_types;

    typedef logic [11:0] lc3b_line_addr;

    typedef enum logic {
        wb_idle  = 1'b0,
        wb_write = 1'b1
    } lc3b_wb_state;

endpackage

// File: rtl/lc3b_writeback_buffer.sv
// Write-back buffer for evicted dirty lines: circular FIFO with address coalescing,
// a fully associative lookup port for misses, and a one-request-at-a-time drain FSM.
module lc3b_writeback_buffer
    import lc3b_types::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned ADDR_W = 12
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [ADDR_W-1:0]            enq_addr,
    input  logic [LINE_W-1:0]            enq_data,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [LINE_W-1:0]            mem_wdata,
    input  logic                         mem_resp,
    input  logic [ADDR_W-1:0]            lookup_addr,
    output logic                         lookup_hit,
    output logic [LINE_W-1:0]            lookup_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count_q;
    lc3b_wb_state      state;

    logic [DEPTH-1:0]  lkp_match;
    logic [DEPTH-1:0]  enq_match;
    logic              lkp_hit;
    logic [PW-1:0]     lkp_sel;
    logic              enq_hit;
    logic [PW-1:0]     enq_sel;
    logic [PW-1:0]     idx;
    logic [PW-1:0]     wr_idx;
    logic              accept;
    logic              append;
    logic              pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign enq_ready = !full;
    assign count     = count_q;
    assign mem_write = (state == wb_write);

    assign accept = enq_valid && enq_ready;
    assign pop    = (state == wb_write) && mem_resp;
    assign append = accept && !enq_hit;
    assign wr_idx = enq_hit ? enq_sel : tail;

    // The head is excluded from coalescing while it is on the memory bus so its data stays stable.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cam
        assign lkp_match[i] = valid[i] && (addr_q[i] == lookup_addr);
        assign enq_match[i] = valid[i] && (addr_q[i] == enq_addr) &&
                              !((state == wb_write) && (PW'(i) == head));
    end

    // Walk from head toward tail so the last match seen is the youngest.
    always_comb begin
        lkp_hit = 1'b0;
        lkp_sel = '0;
        enq_hit = 1'b0;
        enq_sel = '0;
        idx     = head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (lkp_match[idx]) begin
                lkp_hit = 1'b1;
                lkp_sel = idx;
            end
            if (enq_match[idx]) begin
                enq_hit = 1'b1;
                enq_sel = idx;
            end
        end
    end

    assign lookup_hit  = lkp_hit;
    assign lookup_data = lkp_hit ? data_q[lkp_sel] : '0;
    assign mem_addr    = valid[head] ? addr_q[head] : '0;
    assign mem_wdata   = valid[head] ? data_q[head] : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[wr_idx] <= enq_addr;
            data_q[wr_idx] <= enq_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid   <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            state   <= wb_idle;
        end else begin
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (append) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PW'(1);
            end
            count_q <= count_q + CW'(append) - CW'(pop);
            case (state)
                wb_idle:  if (!empty) state <= wb_write;
                wb_write: if (mem_resp) state <= wb_idle;
                default:  state <= wb_idle;
            endcase
        end
    end

endmodule
